// File: rtl/dds_voice_scheduler_if.sv
// Config, sine-table and mix-output signals of the DDS voice scheduler; slave is the scheduler side.
// The table side returns tab_data for tab_phase a fixed TAB_LAT+1 edges after the tab_req edge.
interface dds_voice_scheduler_if #(
    parameter int NV = 4,
    parameter int DW = 32
);
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [$clog2(NV)-1:0]   cfg_voice;
    logic [31:0]             cfg_adder;
    logic                    cfg_gate;
    logic [31:0]             tab_phase;
    logic                    tab_req;
    logic [DW-1:0]           tab_data;
    logic [DW-1:0]           mix_out;
    logic                    mix_valid;

    modport master (
        output cfg_valid, cfg_voice, cfg_adder, cfg_gate, tab_data,
        input  cfg_ready, tab_phase, tab_req, mix_out, mix_valid
    );

    modport slave (
        input  cfg_valid, cfg_voice, cfg_adder, cfg_gate, tab_data,
        output cfg_ready, tab_phase, tab_req, mix_out, mix_valid
    );
endinterface

// File: rtl/dds_voice_scheduler.sv
// Shares one sine table across NV voices; a tick yields one mix sample NV*(TAB_LAT+2)+1 cycles later.
// Config writes stall (cfg_ready=0) while a round runs. `define DDS_SCHED_SKIP_IDLE_EN skips gated-off voices.
module dds_voice_scheduler #(
    parameter int NV      = 4,
    parameter int DW      = 32,
    parameter int TAB_LAT = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  sample_tick,
    input  logic                  ovr_clr,
    output logic                  busy,
    output logic                  overrun,
    dds_voice_scheduler_if.slave  bus
);
    localparam int LV  = $clog2(NV);
    localparam int AW  = DW + LV;
    localparam int WCW = (TAB_LAT > 1) ? $clog2(TAB_LAT) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'((TAB_LAT > 0) ? TAB_LAT - 1 : 0);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ACCUM = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] CAPT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]           state;
    logic [LV-1:0]        v;
    logic [WCW-1:0]       wcnt;
    logic signed [AW-1:0] acc;
    logic [31:0]          phase [NV];
    logic [31:0]          adder [NV];
    logic [NV-1:0]        gate;
    logic                 cfg_fire;
    logic [31:0]          phase_nxt;

    assign busy          = (state != IDLE);
    assign bus.cfg_ready = (state == IDLE);
    assign cfg_fire      = bus.cfg_valid && (state == IDLE);
    assign phase_nxt     = phase[v] + adder[v];

`ifdef DDS_SCHED_SKIP_IDLE_EN
    // Next gated voice: from 0 (with this edge's config write folded in) in IDLE, from v+1 in CAPT.
    logic [NV-1:0] scan_gate;
    logic          nxt_found;
    logic [LV-1:0] nxt_v;

    always_comb begin
        scan_gate = gate;
        if (cfg_fire) scan_gate[bus.cfg_voice] = bus.cfg_gate;
        nxt_found = 1'b0;
        nxt_v     = '0;
        for (int i = NV - 1; i >= 0; i--) begin
            if (scan_gate[i] && ((state == IDLE) || (i > int'(v)))) begin
                nxt_found = 1'b1;
                nxt_v     = LV'(i);
            end
        end
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            v             <= '0;
            wcnt          <= '0;
            acc           <= '0;
            gate          <= '0;
            overrun       <= 1'b0;
            bus.tab_phase <= '0;
            bus.tab_req   <= 1'b0;
            bus.mix_out   <= '0;
            bus.mix_valid <= 1'b0;
            for (int i = 0; i < NV; i++) begin
                phase[i] <= '0;
                adder[i] <= '0;
            end
        end else begin
            bus.tab_req   <= 1'b0;
            bus.mix_valid <= 1'b0;

            if (sample_tick && (state != IDLE)) overrun <= 1'b1;
            else if (ovr_clr)                   overrun <= 1'b0;

            // A rising gate restarts the note at phase 0.
            if (cfg_fire) begin
                adder[bus.cfg_voice] <= bus.cfg_adder;
                gate[bus.cfg_voice]  <= bus.cfg_gate;
                if (bus.cfg_gate && !gate[bus.cfg_voice]) phase[bus.cfg_voice] <= '0;
            end

            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        acc <= '0;
`ifdef DDS_SCHED_SKIP_IDLE_EN
                        v     <= nxt_v;
                        state <= nxt_found ? ACCUM : DONE;
`else
                        v     <= '0;
                        state <= ACCUM;
`endif
                    end
                end
                ACCUM: begin
                    phase[v]      <= phase_nxt;
                    bus.tab_phase <= phase_nxt;
                    bus.tab_req   <= 1'b1;
                    wcnt          <= '0;
                    state         <= (TAB_LAT == 0) ? CAPT : WAIT;
                end
                WAIT: begin
                    if (wcnt == WLAST) state <= CAPT;
                    else               wcnt  <= wcnt + 1'b1;
                end
                CAPT: begin
                    if (gate[v]) acc <= acc + {{LV{bus.tab_data[DW-1]}}, bus.tab_data};
`ifdef DDS_SCHED_SKIP_IDLE_EN
                    v     <= nxt_found ? nxt_v : v;
                    state <= nxt_found ? ACCUM : DONE;
`else
                    if (v == LV'(NV - 1)) begin
                        state <= DONE;
                    end else begin
                        v     <= v + 1'b1;
                        state <= ACCUM;
                    end
`endif
                end
                DONE: begin
                    bus.mix_out   <= acc[AW-1:LV];
                    bus.mix_valid <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dds_voice_scheduler.sv
// Randomized bench for dds_voice_scheduler against a per-round arithmetic model of phases and mix.
module tb_dds_voice_scheduler;
    localparam int NV      = 4;
    localparam int DW      = 32;
    localparam int TAB_LAT = 2;
    localparam int LV      = $clog2(NV);
    localparam int LAT     = NV * (TAB_LAT + 2) + 1;

    logic CLK = 1'b0;
    logic RESET;
    logic sample_tick;
    logic ovr_clr;
    logic busy;
    logic overrun;

    dds_voice_scheduler_if #(.NV(NV), .DW(DW)) bus ();

    dds_voice_scheduler #(.NV(NV), .DW(DW), .TAB_LAT(TAB_LAT)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .sample_tick (sample_tick),
        .ovr_clr     (ovr_clr),
        .busy        (busy),
        .overrun     (overrun),
        .bus         (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Sine table stand-in: a TAB_LAT-deep pipeline of an affine function of the phase.
    logic [31:0]   tab_const;
    logic [31:0]   tab_mul;
    logic [DW-1:0] tab_s1;
    logic [DW-1:0] tab_s2;

    function automatic logic [31:0] tab_fn(input logic [31:0] p);
        return tab_const + p * tab_mul;
    endfunction

    always @(posedge CLK) begin
        tab_s1 <= tab_fn(bus.tab_phase);
        tab_s2 <= tab_s1;
    end
    assign bus.tab_data = tab_s2;

    logic [31:0] tab_q[$];
    always @(negedge CLK) if (bus.tab_req === 1'b1) tab_q.push_back(bus.tab_phase);

    // Reference state
    logic [31:0] m_adder [NV];
    logic [31:0] m_phase [NV];
    bit          m_gate  [NV];
    bit          m_ovr;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_adder[i] = '0;
            m_phase[i] = '0;
            m_gate[i]  = 1'b0;
        end
        m_ovr = 1'b0;
    endtask

    task automatic model_cfg(input int vi, input logic [31:0] a, input bit g);
        if (g && !m_gate[vi]) m_phase[vi] = '0;
        m_adder[vi] = a;
        m_gate[vi]  = g;
    endtask

    task automatic cfg_write(input int vi, input logic [31:0] a, input bit g);
        int cnt;
        bus.cfg_valid = 1'b1;
        bus.cfg_voice = LV'(vi);
        bus.cfg_adder = a;
        bus.cfg_gate  = g;
        cnt = 0;
        while (!bus.cfg_ready && cnt < 100) begin
            @(negedge CLK);
            cnt++;
        end
        check("cfg_accept_bound", 64'(cnt < 100), 64'(1));
        @(negedge CLK);
        bus.cfg_valid = 1'b0;
        model_cfg(vi, a, g);
    endtask

    // One round from tick to mix; dbl>0 re-ticks dbl cycles into the round.
    task automatic do_round(input int dbl, input bit clr_cfg);
        logic [31:0] exp_ph [NV];
        longint      s;
        logic [31:0] exp_mix;
        int          cnt;
        bit          got;
        s = 0;
        for (int i = 0; i < NV; i++) begin
            m_phase[i] = m_phase[i] + m_adder[i];
            exp_ph[i]  = m_phase[i];
            if (m_gate[i]) s += longint'($signed(tab_fn(m_phase[i])));
        end
        exp_mix = 32'(s >>> LV);
        tab_q.delete();
        sample_tick = 1'b1;
        @(negedge CLK);
        sample_tick = 1'b0;
        if (clr_cfg) bus.cfg_valid = 1'b0;
        check("busy_start", 64'(busy), 64'(1));
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < LAT + 20) begin
            @(negedge CLK);
            sample_tick = 1'b0;
            cnt++;
            if (bus.mix_valid) got = 1'b1;
            else if (dbl != 0 && cnt == dbl) begin
                sample_tick = 1'b1;
                m_ovr       = 1'b1;
            end
        end
        check("mix_latency", 64'(cnt), 64'(LAT));
        check("mix_out", 64'(bus.mix_out), 64'(exp_mix));
        check("tab_req_count", 64'(tab_q.size()), 64'(NV));
        for (int i = 0; i < NV; i++)
            if (i < tab_q.size()) check($sformatf("tab_phase_v%0d", i), 64'(tab_q[i]), 64'(exp_ph[i]));
        @(negedge CLK);
        check("mix_valid_pulse", 64'(bus.mix_valid), 64'(0));
        check("idle_after", 64'(busy), 64'(0));
        check("overrun", 64'(overrun), 64'(m_ovr));
    endtask

    task automatic clear_overrun();
        ovr_clr = 1'b1;
        @(negedge CLK);
        ovr_clr = 1'b0;
        m_ovr   = 1'b0;
        check("ovr_clr", 64'(overrun), 64'(m_ovr));
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_busy"},      64'(busy),          64'(0));
        check({tag, "_tab_req"},   64'(bus.tab_req),   64'(0));
        check({tag, "_mix_valid"}, 64'(bus.mix_valid), 64'(0));
        check({tag, "_mix_out"},   64'(bus.mix_out),   64'(0));
        check({tag, "_tab_phase"}, 64'(bus.tab_phase), 64'(0));
        check({tag, "_overrun"},   64'(overrun),       64'(0));
        check({tag, "_cfg_ready"}, 64'(bus.cfg_ready), 64'(1));
    endtask

    initial begin
        RESET = 1'b1;
        sample_tick = 1'b0;
        ovr_clr = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_voice = '0;
        bus.cfg_adder = '0;
        bus.cfg_gate  = 1'b0;
        tab_const = '0;
        tab_mul   = '0;
        model_reset();
        repeat (3) @(negedge CLK);
        reset_checks("reset");
        RESET = 1'b0;
        @(negedge CLK);

        do_round(0, 1'b0);

        tab_const = 32'h4000_0000;
        cfg_write(0, 32'd100000, 1'b1);
        do_round(0, 1'b0);
        do_round(0, 1'b0);

        tab_const = 32'hC000_0000;
        for (int i = 1; i < NV; i++) cfg_write(i, 32'd0, 1'b1);
        do_round(0, 1'b0);

        cfg_write(1, 32'h8000_0000, 1'b1);
        do_round(0, 1'b0);
        do_round(0, 1'b0);
        do_round(0, 1'b0);
        cfg_write(1, 32'h4000_0000, 1'b1);
        do_round(0, 1'b0);
        cfg_write(1, 32'h4000_0000, 1'b0);
        cfg_write(1, 32'h4000_0000, 1'b1);
        do_round(0, 1'b0);

        tab_mul = 32'h0001_0003;
        fork
            do_round(5, 1'b0);
            begin
                repeat (3) @(negedge CLK);
                check("cfg_ready_busy", 64'(bus.cfg_ready), 64'(0));
                cfg_write(2, 32'h0123_4567, 1'b1);
            end
        join
        clear_overrun();
        do_round(0, 1'b0);

        bus.cfg_valid = 1'b1;
        bus.cfg_voice = LV'(3);
        bus.cfg_adder = 32'd12345;
        bus.cfg_gate  = 1'b0;
        model_cfg(3, 32'd12345, 1'b0);
        do_round(0, 1'b1);

        sample_tick = 1'b1;
        @(negedge CLK);
        sample_tick = 1'b0;
        repeat (9) @(negedge CLK);
        RESET = 1'b1;
        #1;
        reset_checks("mid_reset");
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        do_round(0, 1'b0);
        cfg_write(3, 32'd777, 1'b1);
        do_round(0, 1'b0);

        for (int it = 0; it < 20; it++) begin
            int nw;
            int dbl;
            tab_const = $urandom;
            tab_mul   = $urandom;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                cfg_write($urandom_range(0, NV - 1), $urandom, 1'($urandom_range(0, 1)));
            dbl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
            do_round(dbl, 1'b0);
            if (m_ovr) clear_overrun();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
